// File: rtl/sr165_pkg.sv
// Shared types, field positions and frame-to-output mapping for the 74LV165A chain scanner.
package sr165_pkg;

  localparam int unsigned SR_BITS    = 16;
  localparam int unsigned JS1_LSB    = 8;
  localparam int unsigned JS2_LSB    = 0;
  localparam int unsigned JMP_LO_LSB = 5;
  localparam int unsigned JMP_HI_LSB = 13;
  localparam int unsigned JS_BITS    = 5;
  localparam int unsigned JMP_BITS   = 3;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    UPDATE
  } sr165_state_t;

  typedef struct packed {
    logic [JS_BITS-1:0]  joystick1;
    logic [JS_BITS-1:0]  joystick2;
    logic [JMP_BITS-1:0] jumper;
  } sr165_out_t;

  // Jumper lines are wired to both chain halves; either half pulling low asserts it.
  function automatic sr165_out_t frame_fields(input logic [SR_BITS-1:0] raw);
    sr165_out_t f;
    f.joystick1 = raw[JS1_LSB +: JS_BITS];
    f.joystick2 = raw[JS2_LSB +: JS_BITS];
    f.jumper    = raw[JMP_LO_LSB +: JMP_BITS] & raw[JMP_HI_LSB +: JMP_BITS];
    return f;
  endfunction

endpackage

// File: rtl/sr165_debounce.sv
// Whole-frame debouncer: outputs follow a frame only after DEBOUNCE identical frames in a row.
module sr165_debounce
  import sr165_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_done,
  input  logic [SR_BITS-1:0]  raw,
  output logic [JS_BITS-1:0]  joystick1,
  output logic [JS_BITS-1:0]  joystick2,
  output logic [JMP_BITS-1:0] jumper,
  output logic                changed
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SR_BITS-1:0] cand, cand_n;
  logic [CNT_W-1:0]   scnt, scnt_n;
  sr165_out_t         cur, nxt;
  logic               upd;

  // Next candidate/count, and whether the settled candidate alters any visible bit.
  always_comb begin
    cand_n = cand;
    scnt_n = scnt;
    if (frame_done) begin
      if (raw == cand) begin
        if (scnt != CNT_MAX) scnt_n = scnt + CNT_W'(1);
      end else begin
        cand_n = raw;
        scnt_n = CNT_W'(1);
      end
    end
    nxt = frame_fields(cand_n);
    upd = frame_done && (scnt_n >= CNT_W'(DEBOUNCE)) && (nxt != cur);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand    <= '1;
      scnt    <= '0;
      cur     <= '1;
      changed <= 1'b0;
    end else begin
      cand    <= cand_n;
      scnt    <= scnt_n;
      changed <= upd;
      if (upd) cur <= nxt;
    end
  end

  assign joystick1 = cur.joystick1;
  assign joystick2 = cur.joystick2;
  assign jumper    = cur.jumper;

endmodule

// File: rtl/sr165_scan.sv
// Drives the 74LV165A chain (load, shift clock), assembles 16-bit frames and debounces them.
module sr165_scan
  import sr165_pkg::*;
#(
  parameter int unsigned DIV      = 4,
  parameter int unsigned DEBOUNCE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sr_data,
  output logic                sr_clk,
  output logic                sr_load_n,
  output logic [JS_BITS-1:0]  joystick1,
  output logic [JS_BITS-1:0]  joystick2,
  output logic [JMP_BITS-1:0] jumper,
  output logic                frame_done,
  output logic                changed
);

  localparam int unsigned TCNT_W = 8;
  localparam int unsigned BCNT_W = 5;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(DIV - 1);

  sr165_state_t       state, state_n;
  logic [TCNT_W-1:0]  tcnt, tcnt_n;
  logic [BCNT_W-1:0]  bcnt, bcnt_n;
  logic [SR_BITS-1:0] shreg, shreg_n;
  logic               ltick, ltick_n;
  logic               sr_clk_n, sr_load_n_n, frame_done_n;
  logic               tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LOAD;
      tcnt       <= '0;
      bcnt       <= '0;
      ltick      <= 1'b0;
      shreg      <= '1;
      sr_clk     <= 1'b0;
      sr_load_n  <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      tcnt       <= tcnt_n;
      bcnt       <= bcnt_n;
      ltick      <= ltick_n;
      shreg      <= shreg_n;
      sr_clk     <= sr_clk_n;
      sr_load_n  <= sr_load_n_n;
      frame_done <= frame_done_n;
    end
  end

  // QH is valid right after load, so each bit is sampled on the tick that raises sr_clk.
  always_comb begin
    state_n  = state;
    bcnt_n   = bcnt;
    ltick_n  = ltick;
    shreg_n  = shreg;
    sr_clk_n = sr_clk;
    tick     = (tcnt == TCNT_LAST);
    unique case (state)
      LOAD: begin
        sr_clk_n = 1'b0;
        if (tick) begin
          ltick_n = ~ltick;
          if (ltick) begin
            state_n = SHIFT;
            bcnt_n  = '0;
          end
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sr_clk) begin
            shreg_n  = {shreg[SR_BITS-2:0], sr_data};
            sr_clk_n = 1'b1;
            bcnt_n   = bcnt + BCNT_W'(1);
          end else begin
            sr_clk_n = 1'b0;
            if (bcnt == BCNT_W'(SR_BITS)) state_n = UPDATE;
          end
        end
      end
      UPDATE: state_n = LOAD;
      default: state_n = LOAD;
    endcase
    tcnt_n       = (tick || (state_n != state)) ? '0 : tcnt + TCNT_W'(1);
    sr_load_n_n  = (state_n != LOAD);
    frame_done_n = (state_n == UPDATE);
  end

  sr165_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_done (frame_done),
    .raw        (shreg),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .jumper     (jumper),
    .changed    (changed)
  );

endmodule

// File: tb/tb_sr165_scan.sv
// Bench for sr165_scan: behavioural 165 chains feed two instances, checked against a frame-level model.
`timescale 1ns/1ps
module tb_sr165_scan;

  localparam int unsigned DIV_A = 4;
  localparam int unsigned DEB_A = 2;
  localparam int unsigned DIV_B = 1;
  localparam int unsigned DEB_B = 1;
  localparam int unsigned PER_A = 34 * DIV_A + 1;
  localparam int unsigned PER_B = 34 * DIV_B + 1;
  localparam logic [15:0] DIR [17] = '{
    16'hFFFF, 16'hFFFF, 16'hE0E0, 16'hE0E0, 16'hE0E0, 16'h1F1F, 16'h1F1F,
    16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'hFFFF,
    16'h7F7F, 16'h7F7F, 16'hFF7F, 16'hFF7F, 16'hFF7F
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_sr_data, a_sr_clk, a_sr_load_n, a_frame_done, a_changed;
  logic [4:0] a_js1, a_js2;
  logic [2:0] a_jmp;
  logic       b_sr_data, b_sr_clk, b_sr_load_n, b_frame_done, b_changed;
  logic [4:0] b_js1, b_js2;
  logic [2:0] b_jmp;

  sr165_scan #(.DIV(DIV_A), .DEBOUNCE(DEB_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .sr_data(a_sr_data), .sr_clk(a_sr_clk), .sr_load_n(a_sr_load_n),
    .joystick1(a_js1), .joystick2(a_js2), .jumper(a_jmp), .frame_done(a_frame_done), .changed(a_changed)
  );

  sr165_scan #(.DIV(DIV_B), .DEBOUNCE(DEB_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .sr_data(b_sr_data), .sr_clk(b_sr_clk), .sr_load_n(b_sr_load_n),
    .joystick1(b_js1), .joystick2(b_js2), .jumper(b_jmp), .frame_done(b_frame_done), .changed(b_changed)
  );

  // 74LV165A: parallel load while SH/LD low, shift toward QH on rising CLK, serial-in tied high.
  logic [15:0] word_a = 16'hFFFF, chain_a = 16'hFFFF;
  logic [15:0] word_b = 16'hFFFF, chain_b = 16'hFFFF;
  always @(posedge a_sr_clk or negedge a_sr_load_n)
    if (!a_sr_load_n) chain_a <= word_a; else chain_a <= {chain_a[14:0], 1'b1};
  always @(posedge b_sr_clk or negedge b_sr_load_n)
    if (!b_sr_load_n) chain_b <= word_b; else chain_b <= {chain_b[14:0], 1'b1};
  assign a_sr_data = chain_a[15];
  assign b_sr_data = chain_b[15];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] fields(input logic [15:0] r);
    return {r[12:8], r[4:0], r[7:5] & r[15:13]};
  endfunction

  // True when the newest deb frames since reset are all identical.
  function automatic logic settled(input logic [15:0] h[$], input int deb);
    if (h.size() < deb) return 1'b0;
    for (int i = h.size() - deb; i < h.size(); i++)
      if (h[i] != h[h.size()-1]) return 1'b0;
    return 1'b1;
  endfunction

  logic [15:0] hist_a[$];
  logic [15:0] hist_b[$];
  logic [12:0] exp_a = '1, exp_b = '1;
  logic [15:0] cur_a = 16'hFFFF, cur_b = 16'hFFFF;

  // Entry: negedge in the frame_done cycle of the frame holding cur_a. Exit: same point one frame later.
  task automatic a_frame(input logic [15:0] w);
    logic [12:0] nxt;
    logic chg, prev;
    int cyc, low, rises, pulses, drift;
    hist_a.push_back(cur_a);
    chg = 1'b0;
    if (settled(hist_a, DEB_A)) begin
      nxt = fields(cur_a);
      chg = (nxt != exp_a);
      exp_a = nxt;
    end
    word_a = w;
    @(negedge clk);
    check("a_changed", 32'(a_changed), 32'(chg));
    check("a_outputs", 32'({a_js1, a_js2, a_jmp}), 32'(exp_a));
    cyc = 1; low = a_sr_load_n ? 0 : 1; rises = 0; pulses = 0; drift = 0; prev = a_sr_clk;
    while (!a_frame_done && cyc < 3 * PER_A) begin
      @(negedge clk);
      cyc++;
      if (!a_sr_load_n) low++;
      if (a_sr_clk && !prev) rises++;
      prev = a_sr_clk;
      if (a_changed) pulses++;
      if ({a_js1, a_js2, a_jmp} != exp_a) drift++;
    end
    check("a_period", 32'(cyc), 32'(PER_A));
    check("a_load_low", 32'(low), 32'(2 * DIV_A));
    check("a_sclk_rises", 32'(rises), 32'd16);
    check("a_stray_changed", 32'(pulses), 32'd0);
    check("a_hold", 32'(drift), 32'd0);
    cur_a = w;
  endtask

  task automatic b_frame(input logic [15:0] w);
    logic [12:0] nxt;
    logic chg, prev;
    int cyc, low, rises, pulses;
    hist_b.push_back(cur_b);
    chg = 1'b0;
    if (settled(hist_b, DEB_B)) begin
      nxt = fields(cur_b);
      chg = (nxt != exp_b);
      exp_b = nxt;
    end
    word_b = w;
    @(negedge clk);
    check("b_changed", 32'(b_changed), 32'(chg));
    check("b_outputs", 32'({b_js1, b_js2, b_jmp}), 32'(exp_b));
    cyc = 1; low = b_sr_load_n ? 0 : 1; rises = 0; pulses = 0; prev = b_sr_clk;
    while (!b_frame_done && cyc < 3 * PER_B) begin
      @(negedge clk);
      cyc++;
      if (!b_sr_load_n) low++;
      if (b_sr_clk && !prev) rises++;
      prev = b_sr_clk;
      if (b_changed) pulses++;
    end
    check("b_period", 32'(cyc), 32'(PER_B));
    check("b_load_low", 32'(low), 32'(2 * DIV_B));
    check("b_sclk_rises", 32'(rises), 32'd16);
    check("b_stray_changed", 32'(pulses), 32'd0);
    cur_b = w;
  endtask

  // Entry: the negedge at which rst_n was just raised.
  task automatic a_first_frame();
    int cyc;
    @(negedge clk);
    cyc = 1;
    check("a_load_after_rst", 32'(a_sr_load_n), 32'd0);
    while (!a_frame_done && cyc < 3 * PER_A) begin
      @(negedge clk);
      cyc++;
    end
    check("a_first_done", 32'(cyc), 32'(34 * DIV_A));
  endtask

  task automatic check_reset_a();
    check("rst_sr_clk", 32'(a_sr_clk), 32'd0);
    check("rst_load_n", 32'(a_sr_load_n), 32'd1);
    check("rst_outputs", 32'({a_js1, a_js2, a_jmp}), 32'h1FFF);
    check("rst_frame_done", 32'(a_frame_done), 32'd0);
    check("rst_changed", 32'(a_changed), 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    int n, cyc, rises;
    logic prev;

    repeat (3) @(negedge clk);
    check_reset_a();
    check("b_rst_outputs", 32'({b_js1, b_js2, b_jmp}), 32'h1FFF);
    rst_n = 1'b1;
    a_first_frame();

    foreach (DIR[i]) a_frame(DIR[i]);

    repeat (12) begin
      w = 16'($urandom);
      n = $urandom_range(1, 3);
      repeat (n) a_frame(w);
    end

    repeat (3) a_frame(16'hFEFF);

    // Reset pulse in the middle of shifting the next frame.
    word_a = 16'h5A3C;
    cyc = 0; rises = 0; prev = a_sr_clk;
    while (rises < 8 && cyc < 3 * PER_A) begin
      @(negedge clk);
      cyc++;
      if (a_sr_clk && !prev) rises++;
      prev = a_sr_clk;
    end
    check("midshift_reached", 32'(rises), 32'd8);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_a();
    rst_n = 1'b1;
    hist_a.delete();
    exp_a = '1;
    cur_a = 16'h5A3C;
    a_first_frame();
    a_frame(16'h5A3C);
    a_frame(16'hFFFF);
    a_frame(16'hFFFF);

    // Fast instance: wait for its next frame boundary, then alternate words.
    cyc = 0;
    while (!b_frame_done && cyc < 3 * PER_B) begin
      @(negedge clk);
      cyc++;
    end
    check("b_sync", 32'(b_frame_done), 32'd1);
    hist_b.delete();
    exp_b = '1;
    cur_b = 16'hFFFF;
    repeat (4) begin
      b_frame(16'hFFEF);
      b_frame(16'hFFFF);
    end
    b_frame(16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
